// File: rtl/accu_stream.sv
// -----------------------------------------------------------------------------
// accu_stream
//   Streaming accumulator. It sums cfg_len input beats per group, or fewer if
//   flush closes the group early, and emits one result beat per group together
//   with the number of beats summed. Both sides use a valid/ready handshake.
//   Input beats can arrive every cycle with no bubble between groups while
//   results are drained.
//
// Ports
//   clk       in   1       clock, rising edge
//   rst_n     in   1       asynchronous active-low reset
//   data_in   in   DATA_W  input sample
//   valid_a   in   1       data_in valid
//   ready_a   out  1       beat can be accepted this cycle (combinational)
//   flush     in   1       close the group with this beat (only if accepted)
//   cfg_len   in   LEN_W   beats per group, sampled on a group's first beat
//   data_out  out  OUT_W   group sum
//   cnt_out   out  LEN_W   beats summed into data_out
//   valid_b   out  1       data_out/cnt_out valid
//   ready_b   in   1       downstream accepts the result
// -----------------------------------------------------------------------------
module accu_stream #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 4,
    parameter int LEN_W  = 3,
    parameter int OUT_W  = 10,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_a,
    output logic              ready_a,
    input  logic              flush,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [OUT_W-1:0]  data_out,
    output logic [LEN_W-1:0]  cnt_out,
    output logic              valid_b,
    input  logic              ready_b
);

    typedef enum logic {
        IDLE = 1'b0,   // no beat of the current group accepted yet
        ACC  = 1'b1    // group open, at least one beat summed
    } state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   acc;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;

    logic [OUT_W-1:0]   ext_in;
    logic [OUT_W-1:0]   sum;
    logic [LEN_W-1:0]   cnt_inc;
    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W-1:0]   len_eff;
    logic               beat_last;
    logic               accept;

    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        // Extend the sample to the result width.
        if (SIGNED != 0) ext_in = OUT_W'($signed(data_in));
        else             ext_in = OUT_W'(data_in);

        // Clamp the requested group length into 1..MAX_N.
        len_clamp = cfg_len;
        if (cfg_len == '0)
            len_clamp = LEN_W'(1);
        else if (cfg_len > LEN_W'(MAX_N))
            len_clamp = LEN_W'(MAX_N);

        // cfg_len is used only for a group's first beat. After that the
        // latched length applies.
        len_eff = (state == IDLE) ? len_clamp : len_q;

        // acc and cnt are zero in IDLE, so the same sum and increment serve
        // both the first beat and the later beats of a group.
        cnt_inc   = cnt + LEN_W'(1);
        sum       = acc + ext_in;
        beat_last = flush || (cnt_inc == len_eff);

        // A group-closing beat needs room in the output register. Other beats
        // can always be accepted.
        ready_a = !(valid_b && !ready_b && beat_last);
        accept  = valid_a && ready_a;

        state_nxt = state;
        if (accept)
            state_nxt = beat_last ? IDLE : ACC;
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the edge, whatever the order
    // in which the blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Running sum for the open group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else if (accept) begin
            if (beat_last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt_inc;
            end
            if (state == IDLE)
                len_q <= len_clamp;
        end
    end

    // Output register. A new result can load in the same cycle the previous
    // one transfers, so valid_b stays high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            cnt_out  <= '0;
            valid_b  <= 1'b0;
        end else if (accept && beat_last) begin
            data_out <= sum;
            cnt_out  <= cnt_inc;
            valid_b  <= 1'b1;
        end else if (valid_b && ready_b) begin
            valid_b  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accu_stream.sv
// -----------------------------------------------------------------------------
// tb_accu_stream
//   Self-checking bench for accu_stream. An unsigned instance and a signed
//   instance share one input stream. A reference model built from integer
//   sums and beat counts predicts ready_a and the result beat of each
//   instance.
// -----------------------------------------------------------------------------
module tb_accu_stream;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 4;
    localparam int LEN_W  = 3;
    localparam int OUT_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              valid_a = 1'b0;
    logic              flush = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              ready_b = 1'b0;

    logic              ready_a_u, ready_a_s;
    logic [OUT_W-1:0]  data_out_u, data_out_s;
    logic [LEN_W-1:0]  cnt_out_u, cnt_out_s;
    logic              valid_b_u, valid_b_s;

    always #5 clk = ~clk;

    accu_stream #(.DATA_W(DATA_W), .MAX_N(MAX_N), .LEN_W(LEN_W),
                  .OUT_W(OUT_W), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a),
        .ready_a(ready_a_u), .flush(flush), .cfg_len(cfg_len),
        .data_out(data_out_u), .cnt_out(cnt_out_u), .valid_b(valid_b_u),
        .ready_b(ready_b)
    );

    accu_stream #(.DATA_W(DATA_W), .MAX_N(MAX_N), .LEN_W(LEN_W),
                  .OUT_W(OUT_W), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a),
        .ready_a(ready_a_s), .flush(flush), .cfg_len(cfg_len),
        .data_out(data_out_s), .cnt_out(cnt_out_s), .valid_b(valid_b_s),
        .ready_b(ready_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the open group and the result currently on offer.
    int               m_cnt, m_len, m_sum_u, m_sum_s;
    bit               exp_valid;
    logic [OUT_W-1:0] exp_u, exp_s;
    int               exp_cnt;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l == 0)     return 1;
        if (l > MAX_N)  return MAX_N;
        return l;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_len = 0; m_sum_u = 0; m_sum_s = 0;
        exp_valid = 1'b0; exp_u = '0; exp_s = '0; exp_cnt = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        valid_a = 1'b0;
        flush   = 1'b0;
        #1;
        model_clear();
        check("rst_valid_b_u", valid_b_u, 0);
        check("rst_valid_b_s", valid_b_s, 0);
        check("rst_data_out_u", data_out_u, 0);
        check("rst_data_out_s", data_out_s, 0);
        check("rst_cnt_out_u", cnt_out_u, 0);
        check("rst_ready_a_u", ready_a_u, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive the inputs, check ready_a, step the model at the
    // clock edge, then check both result ports.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit f,
                        input logic [LEN_W-1:0] l, input bit rb);
        int  len_e;
        bit  last, exp_ready, take, xfer;
        @(negedge clk);
        valid_a = v; data_in = d; flush = f; cfg_len = l; ready_b = rb;
        #1;
        len_e     = (m_cnt == 0) ? clamp_len(int'(l)) : m_len;
        last      = f || (m_cnt + 1 == len_e);
        exp_ready = !(exp_valid && !rb && last);
        check("ready_a_u", ready_a_u, exp_ready);
        check("ready_a_s", ready_a_s, exp_ready);
        take = v && exp_ready;
        xfer = exp_valid && rb;
        @(posedge clk);
        #1;
        if (take) begin
            if (m_cnt == 0) m_len = len_e;
            m_cnt++;
            m_sum_u += int'(d);
            m_sum_s += int'($signed(d));
            if (last) begin
                exp_valid = 1'b1;
                exp_u     = m_sum_u[OUT_W-1:0];
                exp_s     = m_sum_s[OUT_W-1:0];
                exp_cnt   = m_cnt;
                m_cnt = 0; m_sum_u = 0; m_sum_s = 0;
            end else if (xfer) begin
                exp_valid = 1'b0;
            end
        end else if (xfer) begin
            exp_valid = 1'b0;
        end
        check("valid_b_u", valid_b_u, exp_valid);
        check("valid_b_s", valid_b_s, exp_valid);
        if (exp_valid) begin
            check("data_out_u", data_out_u, exp_u);
            check("data_out_s", data_out_s, exp_s);
            check("cnt_out_u", cnt_out_u, exp_cnt);
            check("cnt_out_s", cnt_out_s, exp_cnt);
        end
    endtask

    task automatic idle(input bit rb);
        step(1'b0, '0, 1'b0, '0, rb);
    endtask

    initial begin
        model_clear();
        apply_reset();

        // Basic group of four beats.
        step(1, 8'd10, 0, 3'd4, 1);
        step(1, 8'd20, 0, 3'd4, 1);
        step(1, 8'd30, 0, 3'd4, 1);
        step(1, 8'd40, 0, 3'd4, 1);
        check("basic_sum", data_out_u, 100);
        check("basic_cnt", cnt_out_u, 4);
        idle(1);
        check("basic_drop", valid_b_u, 0);

        // Largest unsigned samples: no wrap.
        repeat (4) step(1, 8'hFF, 0, 3'd4, 1);
        check("max_unsigned", data_out_u, 10'h3FC);
        idle(1);

        // Signed sum -1 - 2 + 5.
        step(1, 8'hFF, 0, 3'd3, 1);
        step(1, 8'hFE, 0, 3'd3, 1);
        step(1, 8'h05, 0, 3'd3, 1);
        check("signed_sum", data_out_s, 10'h002);
        check("signed_cnt", cnt_out_s, 3);
        idle(1);

        // Early flush, then a fresh group with a different length.
        step(1, 8'd7, 0, 3'd4, 1);
        step(1, 8'd8, 1, 3'd4, 1);
        check("flush_sum", data_out_u, 15);
        check("flush_cnt", cnt_out_u, 2);
        step(1, 8'd1, 0, 3'd2, 1);
        step(1, 8'd2, 0, 3'd2, 1);
        check("after_flush_sum", data_out_u, 3);
        idle(1);

        // Flush without valid_a is ignored.
        step(0, 8'd0, 1, 3'd1, 1);
        check("empty_flush", valid_b_u, 0);

        // Backpressure: result held, final beat stalled, back-to-back handover.
        step(1, 8'd1, 0, 3'd2, 0);
        step(1, 8'd2, 0, 3'd2, 0);
        step(1, 8'd3, 0, 3'd2, 0);
        check("bp_hold", data_out_u, 3);
        step(1, 8'd4, 0, 3'd2, 0);
        check("bp_still_held", data_out_u, 3);
        step(1, 8'd4, 0, 3'd2, 1);
        check("bp_b2b_valid", valid_b_u, 1);
        check("bp_b2b_sum", data_out_u, 7);
        idle(1);

        // Length clamping.
        step(1, 8'd9, 0, 3'd0, 1);
        check("clamp0_sum", data_out_u, 9);
        check("clamp0_cnt", cnt_out_u, 1);
        idle(1);
        repeat (4) step(1, 8'd2, 0, 3'd6, 1);
        check("clamp6_cnt", cnt_out_u, 4);
        idle(1);

        // Reset in the middle of a group discards the partial sum.
        step(1, 8'd5, 0, 3'd4, 1);
        step(1, 8'd6, 0, 3'd4, 1);
        apply_reset();
        repeat (3) idle(1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 DATA_W'($urandom_range(0, 255)),
                 $urandom_range(0, 9) == 0,
                 LEN_W'($urandom_range(0, 7)),
                 $urandom_range(0, 4) < 3);
        end
        repeat (3) idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
